uart_loader: RTL and testbench
==============================

// Module: uart_loader
// PURPOSE
//  Boot loader directly downstream of the UART byte receiver. Consumes received bytes
//  (rx_valid strobe + rx_data), parses a length header, assembles little-endian 32-bit
//  words and writes them to instruction memory from word address 0. Holds the CPU in
//  reset until the image is fully written, then releases it.
// PARAMETERS
//  ADDR_W       12          imem word-address width; capacity = 2**ADDR_W words
//  TIMEOUT_CYC  10_000_000  idle cycles between bytes before a partial load is aborted (100 ms @ 100 MHz)
// PORTS
//  clk          in   1       system clock, 100 MHz
//  rst_n        in   1       asynchronous, active-low reset
//  rx_valid     in   1       1-cycle strobe: rx_data holds a new received byte
//  rx_data      in   8       received byte, valid only while rx_valid=1
//  imem_we      out  1       imem write enable, 1-cycle pulse per word
//  imem_addr    out  ADDR_W  imem word address
//  imem_wdata   out  32      imem write data
//  cpu_rst_n    out  1       CPU reset, active-low; 0 until load completes
//  load_done    out  1       sticky: image fully written
//  load_err     out  1       sticky: header length exceeds capacity
// BEHAVIOUR
//  Reset: rst_n is asynchronous, active-low; clock is clk. All outputs registered.
//   imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0.
//   Internal state -> S_LEN, byte/word counters=0.
//  Stream format: 4 length bytes N (LSB first, 32 bits, units = words), then N words,
//   4 bytes each, LSB first.
//  States:
//   S_LEN:  each rx_valid shifts a byte into len[31:0] (byte k -> bits 8k+7:8k).
//           On the 4th byte: N==0 -> S_DONE; N>2**ADDR_W -> S_ERR; else -> S_DATA.
//   S_DATA: each rx_valid places a byte into word[8k+7:8k], k=byte_cnt (0..3).
//           On byte 3 (rx_valid at cycle t): at cycle t+1, imem_we=1,
//           imem_wdata = {b3,b2,b1,b0}, imem_addr = word index (0,1,2,...).
//           imem_we is 0 in every other cycle. If this was word N-1 -> S_DONE.
//   S_DONE: at cycle t+2 (one cycle after the final imem_we): cpu_rst_n=1, load_done=1.
//           For N==0: both at cycle t+1 after the 4th length byte, with no imem_we.
//           All further rx_valid ignored until reset.
//   S_ERR:  load_err=1 at cycle t+1; cpu_rst_n stays 0; rx ignored until reset.
//  Throughput: rx_valid on every consecutive cycle is accepted without loss.
//  Timeout: idle counter clears on every rx_valid and counts otherwise. It is active only
//   in S_DATA, or in S_LEN with >=1 header byte received. When the count reaches
//   TIMEOUT_CYC-1: -> S_LEN, all byte/word counters and len cleared, imem_addr=0.
//   No flag is raised. Words already written stay in imem and are overwritten by the
//   next load.
//  Widths: word counter is ADDR_W+1 bits (N may equal 2**ADDR_W). imem_addr is the
//   low ADDR_W bits. Comparison of N against capacity uses the full 32 bits.
//  Reset mid-load: immediate return to reset values; the next stream starts at header.
//  Simultaneous: rx_valid in the same cycle the timeout fires -> the byte is accepted
//   and the timeout is suppressed.
// TESTING
//  1 Hold rst_n=0 and pulse rx_valid -> all outputs stay at reset values, no imem_we.
//  2 Bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> two writes: addr0=0x00000013,
//    then addr1=0x00100093; cpu_rst_n=1 and load_done=1 one cycle after the 2nd write.
//  3 Bytes 00 00 00 00 -> load_done=1, cpu_rst_n=1 next cycle, zero imem_we pulses.
//  4 ADDR_W=12, header 01 10 00 00 (N=4097) -> load_err=1, cpu_rst_n=0, later bytes
//    produce no writes. Header 00 10 00 00 (N=4096) is accepted; last write at addr 0xFFF.
//  5 TIMEOUT_CYC=100: header N=1, then 2 data bytes, then 100 idle cycles -> back to S_LEN.
//    Full stream 01 00 00 00 EF BE AD DE -> addr0=0xDEADBEEF, load_done=1.
//  6 Header plus 8 data bytes driven on consecutive cycles -> two writes, each exactly
//    1 cycle after its 4th byte. Repeat with rst_n pulsed after 5 data bytes -> outputs
//    reset; a fresh stream loads correctly from addr 0.

Source files
------------

// File: rtl/uart_loader.sv
// Boot loader fed by the UART byte receiver: parses a word-count header, packs little-endian
// words into imem from address 0, and releases the CPU from reset once the image is complete.
module uart_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned IdleW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] Capacity = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {StLen, StData, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              timeout_active;
  logic              timeout;
  logic [31:0]       len_full;
  logic [ADDR_W:0]   word_cnt_nxt;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    word_d       = word_q;
    idle_d       = idle_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    len_full     = {rx_data, len_q[23:0]};
    word_cnt_nxt = word_cnt_q + 1'b1;

    // Idle timer only runs while a load is partially received.
    timeout_active = (state_q == StData) || ((state_q == StLen) && (byte_cnt_q != 2'd0));
    timeout        = !rx_valid && timeout_active && (idle_q == IdleMax);

    if (rx_valid || !timeout_active) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    unique case (state_q)
      StLen: begin
        if (rx_valid) begin
          len_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_cnt_d = '0;
            if (len_full == 32'd0) begin
              state_d     = StDone;
              load_done_d = 1'b1;
              cpu_rst_n_d = 1'b1;
            end else if (len_full > Capacity) begin
              state_d    = StErr;
              load_err_d = 1'b1;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = {rx_data, word_q[23:0]};
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            word_cnt_d   = word_cnt_nxt;
            if (word_cnt_nxt == len_q[ADDR_W:0]) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        cpu_rst_n_d = 1'b1;
        load_done_d = 1'b1;
      end
      StErr: begin
        load_err_d = 1'b1;
      end
      default: state_d = StLen;
    endcase

    // Abandon a stalled partial load; already-written words are simply overwritten later.
    if (timeout) begin
      state_d     = StLen;
      byte_cnt_d  = '0;
      word_cnt_d  = '0;
      len_d       = '0;
      word_d      = '0;
      imem_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StLen;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      word_q       <= '0;
      idle_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      word_q       <= word_d;
      idle_q       <= idle_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: expected imem writes are queued as bytes are driven and
// matched against every imem_we pulse; status outputs are checked at fixed cycle offsets.
module tb_uart_loader;

  localparam int unsigned AW = 12;

  logic          clk;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];

  uart_loader #(
    .ADDR_W     (AW),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e[AW+31:32]));
        chk("write_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8]);
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input bit expect_wr);
    if (expect_wr) exp_q.push_back({a, w});
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (k == 1) chk("we_between_words", 64'(imem_we), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    chk({tag, "_done"}, 64'(load_done), 64'd0);
    chk({tag, "_err"}, 64'(load_err), 64'd0);
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;

    // 1: bytes during reset are ignored
    idle(2);
    send_hdr(32'd1);
    send_byte(8'h55);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    idle(1);
    chk_reset_outputs("after_reset");

    // 2: two-word image
    send_hdr(32'd2);
    send_word(12'd0, 32'h0000_0013, 1'b1);
    chk("t2_cpu_held", 64'(cpu_rst_n), 64'd0);
    send_word(12'd1, 32'h0010_0093, 1'b1);
    chk("t2_we_last", 64'(imem_we), 64'd1);
    chk("t2_done_not_yet", 64'(load_done), 64'd0);
    idle(1);
    chk("t2_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("t2_done", 64'(load_done), 64'd1);
    chk("t2_err", 64'(load_err), 64'd0);
    send_word(12'd0, 32'h1234_5678, 1'b0);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // 3: empty image
    do_reset();
    send_hdr(32'd0);
    chk("t3_done", 64'(load_done), 64'd1);
    chk("t3_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("t3_we", 64'(imem_we), 64'd0);
    send_word(12'd0, 32'hAABB_CCDD, 1'b0);
    chk("t3_done_sticky", 64'(load_done), 64'd1);

    // 4: capacity boundary
    do_reset();
    send_hdr(32'd4097);
    chk("t4_err", 64'(load_err), 64'd1);
    chk("t4_cpu_held", 64'(cpu_rst_n), 64'd0);
    chk("t4_not_done", 64'(load_done), 64'd0);
    send_word(12'd0, 32'h0102_0304, 1'b0);
    send_word(12'd1, 32'h0506_0708, 1'b0);
    chk("t4_err_sticky", 64'(load_err), 64'd1);
    do_reset();
    chk("t4_err_cleared", 64'(load_err), 64'd0);
    send_hdr(32'd4096);
    for (int i = 0; i < 4096; i++) begin
      send_word(AW'(i), {4'hA, 12'(i), 16'(i) ^ 16'h5A5A}, 1'b1);
    end
    chk("t4_last_addr", 64'(imem_addr), 64'hFFF);
    chk("t4_last_we", 64'(imem_we), 64'd1);
    idle(1);
    chk("t4_full_done", 64'(load_done), 64'd1);
    chk("t4_full_no_err", 64'(load_err), 64'd0);

    // 5: idle timeout abandons a partial load
    do_reset();
    send_hdr(32'd1);
    send_byte(8'hEF);
    send_byte(8'hBE);
    idle(100);
    chk("t5_not_done_after_timeout", 64'(load_done), 64'd0);
    send_hdr(32'd1);
    send_word(12'd0, 32'hDEAD_BEEF, 1'b1);
    idle(1);
    chk("t5_done", 64'(load_done), 64'd1);

    // 6: back-to-back bytes, then a reset mid-load
    do_reset();
    send_hdr(32'd2);
    send_word(12'd0, 32'h1111_2222, 1'b1);
    chk("t6_we_w0", 64'(imem_we), 64'd1);
    send_word(12'd1, 32'h3333_4444, 1'b1);
    chk("t6_we_w1", 64'(imem_we), 64'd1);
    idle(1);
    chk("t6_done", 64'(load_done), 64'd1);
    do_reset();
    send_hdr(32'd2);
    send_word(12'd0, 32'h5555_6666, 1'b1);
    send_byte(8'h77);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_hdr(32'd1);
    send_word(12'd0, 32'hCAFE_F00D, 1'b1);
    chk("t6_fresh_addr", 64'(imem_addr), 64'd0);
    idle(1);
    chk("t6_fresh_done", 64'(load_done), 64'd1);

    idle(3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
